// File: rtl/add6_arbiter_pkg.sv
// Shared constants and FSM state type for the two-requester 6-bit adder.
// Operands are OP_W bits wide and are added HALF_W bits per pass.
// The result is assembled over two passes by a single shared adder.
package add6_arbiter_pkg;

  localparam int HALF_W = 3;
  localparam int OP_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/add6_arbiter_add3c.sv
// Purpose: combinational 3-bit ripple-carry adder with carry in and carry out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the adder has no handshake.
// Ports: a, b - addends; cin - carry in; sum - sum bits; cout - carry out of the top bit.
module add3c
  import add6_arbiter_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);

  logic c1;
  logic c2;

  // The carries are named individually so the ripple chain stays easy to follow.
  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign cout   = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));

endmodule

// File: rtl/add6_arbiter.sv
// Purpose: two requesters share one 3-bit adder; a 6-bit sum is built in a low pass, then a high pass.
// Latency: res_valid rises 2 cycles after the accept edge; accepts are spaced at least 4 cycles apart.
// Backpressure: the block stays in DONE with the result held stable until res_ready; both readies stay 0 while busy.
// Ports: reqN_valid/reqN_a/reqN_b/reqN_ready - requester N operand handshake;
//        res_valid/res_sum/res_cout/res_id/res_ready - result handshake; clk, rst_n (async, active low).
module add6_arbiter
  import add6_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [OP_W-1:0] req0_a,
  input  logic [OP_W-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [OP_W-1:0] req1_a,
  input  logic [OP_W-1:0] req1_b,
  output logic            req1_ready,
  output logic            res_valid,
  output logic [OP_W-1:0] res_sum,
  output logic            res_cout,
  output logic            res_id,
  input  logic            res_ready
);

  state_e              state_q, state_d;
  logic                last_id_q, last_id_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic                id_q, id_d;
  logic [HALF_W-1:0]   lo_sum_q, lo_sum_d;
  logic                lo_carry_q, lo_carry_d;
  logic                res_valid_q, res_valid_d;
  logic [OP_W-1:0]     res_sum_q, res_sum_d;
  logic                res_cout_q, res_cout_d;
  logic                res_id_q, res_id_d;

  logic                grant_vld;
  logic                grant_id;
  logic [HALF_W-1:0]   add_a;
  logic [HALF_W-1:0]   add_b;
  logic                add_cin;
  logic [HALF_W-1:0]   add_sum;
  logic                add_cout;

  add3c u_add3c (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Under contention the requester that did not own the last result wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  // rst_n gating keeps the readies at 0 while reset is held, even if a valid is already up.
  assign req0_ready = rst_n && (state_q == IDLE) && grant_vld && !grant_id;
  assign req1_ready = rst_n && (state_q == IDLE) && grant_vld &&  grant_id;

  // The high pass is selected only in HIGH; every other state presents the low half.
  always_comb begin
    if (state_q == HIGH) begin
      add_a   = a_q[OP_W-1:HALF_W];
      add_b   = b_q[OP_W-1:HALF_W];
      add_cin = lo_carry_q;
    end else begin
      add_a   = a_q[HALF_W-1:0];
      add_b   = b_q[HALF_W-1:0];
      add_cin = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    lo_sum_d    = lo_sum_q;
    lo_carry_d  = lo_carry_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          id_d    = grant_id;
          state_d = LOW;
        end
      end
      LOW: begin
        lo_sum_d   = add_sum;
        lo_carry_d = add_cout;
        state_d    = HIGH;
      end
      HIGH: begin
        // Result registers are loaded only here, so they hold their value outside DONE.
        res_sum_d   = {add_sum, lo_sum_q};
        res_cout_d  = add_cout;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          last_id_d   = res_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      lo_sum_q    <= '0;
      lo_carry_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      lo_sum_q    <= lo_sum_d;
      lo_carry_q  <= lo_carry_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_add6_arbiter.sv
// Testbench for add6_arbiter: directed requests, a scoreboard queue of expected results,
// and a monitor that compares each result when it is handed off.
module tb_add6_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [5:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_cout, res_id, res_ready;
  logic [5:0] res_sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic       id;
    logic [5:0] sum;
    logic       cout;
  } exp_t;

  exp_t sb[$];

  add6_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on each rising res_valid, then scoreboard compare at each handshake.
  int   acc_edge = 0;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_edge = cyc + 1;
      if (res_valid && !prev_vld) check("latency_edge", cyc, acc_edge + 2);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id %0d sum %0d, no result expected", res_id, res_sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_sum",  res_sum,  e.sum);
          check("res_cout", res_cout, e.cout);
          check("res_id",   res_id,   e.id);
        end
      end
    end
    prev_vld = res_valid;
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input bit who, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] es, input bit ec, input bit push);
    bit got;
    got = 1'b0;
    if (push) sb.push_back('{id: who, sum: es, cout: ec});
    if (who) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else     begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: requester %0d never got ready", who);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_res_valid"},  res_valid,  0);
    check({tag, "_res_sum"},    res_sum,    0);
    check({tag, "_res_cout"},   res_cout,   0);
    check({tag, "_res_id"},     res_id,     0);
    check({tag, "_req0_ready"}, req0_ready, 0);
    check({tag, "_req1_ready"}, req1_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int last_acc;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b1;   // a valid during reset must not raise ready
    #1;
    check_outputs_zero("reset");
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention straight out of reset: owners alternate 0,1,0,1, one accept every 4 cycles.
    sb.push_back('{id: 1'b0, sum: 6'd30, cout: 1'b0});
    sb.push_back('{id: 1'b1, sum: 6'd6,  cout: 1'b1});
    sb.push_back('{id: 1'b0, sum: 6'd30, cout: 1'b0});
    sb.push_back('{id: 1'b1, sum: 6'd6,  cout: 1'b1});
    req0_a = 6'd10; req0_b = 6'd20; req1_a = 6'd40; req1_b = 6'd30;
    req0_valid = 1'b1; req1_valid = 1'b1;
    acc = 0;
    last_acc = 0;
    for (int n = 0; n < 100 && acc < 4; n++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        @(posedge clk);
        #1;
        acc++;
        if (acc > 1) check("accept_spacing", cyc - last_acc, 4);
        last_acc = cyc;
        if (acc == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    check("contention_accepts", acc, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Single request and overflow case.
    issue(1'b0, 6'd5,  6'd3,  6'd8,  1'b0, 1'b1);
    drain();
    issue(1'b1, 6'd63, 6'd63, 6'd62, 1'b1, 1'b1);
    drain();

    // Backpressure: result held 5 cycles in DONE while both valids are asserted.
    res_ready = 1'b0;
    issue(1'b0, 6'd33, 6'd17, 6'd50, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid",  res_valid,  1);
      check("bp_res_sum",    res_sum,    50);
      check("bp_res_cout",   res_cout,   0);
      check("bp_res_id",     res_id,     0);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_req1_ready", req1_ready, 0);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_res_valid", res_valid, 0);
    req1_valid = 1'b1;
    #1;
    check("bp_idle_req1_ready", req1_ready, 1);
    req1_valid = 1'b0;
    check("bp_scoreboard_empty", sb.size(), 0);
    @(posedge clk);
    #1;

    // Reset while the high pass is in progress: outputs clear at once, result is lost.
    issue(1'b0, 6'd12, 6'd34, 6'd46, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lost_res_valid", res_valid, 0);
    issue(1'b0, 6'd7, 6'd1, 6'd8, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add6_arbiter.md
ADD6_ARBITER -- requirements
Module: add6_arbiter

Interface
REQ-001 Parameters: none; all widths are fixed constants from the shared package.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ0_VALID  input  1  requester 0 has an operand pair.
REQ-005 REQ0_A  input  6  requester 0 addend A.
REQ-006 REQ0_B  input  6  requester 0 addend B.
REQ-007 REQ0_READY  output  1  block accepts requester 0 this cycle.
REQ-008 REQ1_VALID, REQ1_A, REQ1_B, REQ1_READY  same directions, widths and meanings as requester 0, for requester 1.
REQ-009 RES_VALID  output  1  result available.
REQ-010 RES_SUM  output  6  sum bits [5:0].
REQ-011 RES_COUT  output  1  carry out of bit 5.
REQ-012 RES_ID  output  1  requester that owns the result.
REQ-013 RES_READY  input  1  consumer accepts result.

Function
REQ-014 Block SHALL share one 3-bit adder with carry-in between two requesters, computing a 6-bit sum in two passes: low half, then high half.
REQ-015 FSM SHALL have states IDLE, LOW, HIGH, DONE.
REQ-016 IDLE: REQx_READY SHALL be 1 only for the granted requester; all other READY outputs 0.
REQ-017 Grant: one VALID -> that requester; both VALID -> requester != LAST_ID; neither -> no grant, both READY 0.
REQ-018 Transfer on REQx_VALID & REQx_READY at a rising edge: latch A, B, ID; go to LOW.
REQ-019 LOW: adder inputs A[2:0], B[2:0], Cin=0; register SUM[2:0] and carry; go to HIGH.
REQ-020 HIGH: adder inputs A[5:3], B[5:3], Cin=registered low carry; register SUM[5:3] and COUT; go to DONE.
REQ-021 DONE: RES_VALID=1; RES_SUM, RES_COUT, RES_ID SHALL be stable until handshake.
REQ-022 On RES_VALID & RES_READY: go to IDLE; LAST_ID <= RES_ID.
REQ-023 Latency: RES_VALID SHALL rise two cycles after the accept edge; minimum accept-to-accept spacing is 4 cycles.
REQ-024 READY outputs SHALL be 0 in LOW, HIGH and DONE; VALID held during these states SHALL be ignored, not queued.
REQ-025 VALID dropped before accept SHALL have no effect; no request latched.
REQ-026 Arithmetic SHALL be unsigned modulo 64 with carry reported: 63+63 -> SUM 62, COUT 1.
REQ-027 Outside DONE, RES_VALID SHALL be 0; RES_SUM, RES_COUT, RES_ID SHALL hold their last values.

Reset
REQ-028 RST_N low SHALL immediately force state IDLE, LAST_ID=1, and all outputs and data registers 0, abandoning any in-flight operation.
REQ-029 After RST_N rises, the first grant under contention SHALL go to requester 0.

Structure
REQ-030 Shared package add6_arbiter_pkg SHALL hold the state enum (IDLE, LOW, HIGH, DONE) and constants HALF_W=3 and OP_W=6.
REQ-031 Adder SHALL be one sub-module instance, add3c: a combinational 3-bit ripple-carry adder with Cin and Cout.
REQ-032 Output registers SHALL drive the result ports directly, with no combinational path from the adder.

Verification
REQ-033 Reset: pulse RST_N low mid-cycle -> all outputs 0 without waiting for a clock edge; FSM in IDLE.
REQ-034 Single request: REQ0 A=5, B=3 -> RES_SUM=8, COUT=0, ID=0; RES_VALID high 2 cycles after accept.
REQ-035 Overflow: REQ1 A=63, B=63 -> RES_SUM=62, COUT=1, ID=1.
REQ-036 Contention: both VALID held continuously, RES_READY=1 -> RES_ID sequence 0,1,0,1, one result per 4 cycles.
REQ-037 Backpressure: RES_READY=0 for 5 cycles in DONE -> RES_* stable, both READY=0; release -> IDLE next cycle.
REQ-038 Reset in HIGH: assert RST_N low -> outputs 0, result lost; next REQ0 A=7, B=1 -> SUM=8, ID=0.
